// File: rtl/pad_reader_pkg.sv
// Shared types, default 50 MHz timing constants and width helpers for the
// multi-pad shift-register controller reader.
package pad_reader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SAMPLE   = 3'd2,
    PULSE_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int unsigned DEF_NUM_PADS     = 32'd2;
  localparam int unsigned DEF_NUM_BUTTONS  = 32'd8;
  localparam int unsigned DEF_LATCH_CYCLES = 32'd600;     // 12 us @ 50 MHz
  localparam int unsigned DEF_PULSE_CYCLES = 32'd300;     // 6 us half-period @ 50 MHz
  localparam int unsigned DEF_POLL_CYCLES  = 32'd833333;  // 60 Hz @ 50 MHz

  // Bits needed for a counter that runs 0 .. max_count-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    if (max_count > 32'd1) begin
      return $clog2(max_count);
    end else begin
      return 32'd1;
    end
  endfunction

  // Largest of three interval lengths, used to size the shared timer.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Parametrised-width two-flop synchroniser with synchronous active-high reset.
module pad_sync #(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two register stages bring the asynchronous pad lines into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= raw;
      sync_r <= meta_r;
    end
  end

  assign synced = sync_r;

endmodule

// File: rtl/multi_pad_reader.sv
// Polls NUM_PADS NES/SNES-style shift-register pads sharing one latch and one
// pulse line; publishes an atomic, active-high button word once per frame.
// Optional build macro PAD_EDGE_DET_EN adds the `pressed` newly-pressed output.
module multi_pad_reader
  import pad_reader_pkg::*;
#(
  parameter int unsigned NUM_PADS     = DEF_NUM_PADS,
  parameter int unsigned NUM_BUTTONS  = DEF_NUM_BUTTONS,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned POLL_CYCLES  = DEF_POLL_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_PADS-1:0]             pad_data,
  output logic                            pad_latch,
  output logic                            pad_pulse,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic                            frame_valid,
  output logic                            busy
`ifdef PAD_EDGE_DET_EN
  ,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] pressed
`endif
);

  localparam int unsigned TMR_W = cnt_width(max3(LATCH_CYCLES, PULSE_CYCLES, POLL_CYCLES));
  localparam int unsigned IDX_W = cnt_width(NUM_BUTTONS);

  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(32'd1);
  localparam logic [TMR_W-1:0] LATCH_LAST = TMR_W'(LATCH_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] POLL_LAST  = TMR_W'(POLL_CYCLES - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BUTTONS - 32'd1);

  state_t                                     state_r;
  logic [TMR_W-1:0]                           timer_r;
  logic [IDX_W-1:0]                           idx_r;
  logic [NUM_PADS-1:0][NUM_BUTTONS-1:0]       shift_r;
  logic [NUM_PADS-1:0][NUM_BUTTONS-1:0]       shift_next_s;
  logic [NUM_PADS-1:0][NUM_BUTTONS-1:0]       buttons_r;
  logic [NUM_PADS-1:0]                        sync_s;
  logic                                       pad_latch_r;
  logic                                       pad_pulse_r;
  logic                                       frame_valid_r;
  logic                                       busy_r;
  logic                                       sample_end_s;
  logic                                       frame_end_s;

  pad_sync #(
    .WIDTH (NUM_PADS)
  ) u_pad_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (pad_data),
    .synced (sync_s)
  );

  assign sample_end_s = (state_r == SAMPLE) && (timer_r == PULSE_LAST);
  assign frame_end_s  = sample_end_s && (idx_r == IDX_LAST);

  // Shift registers with the current bit of every pad merged in (pads are active-low).
  always_comb begin
    shift_next_s = shift_r;
    for (int p = 0; p < int'(NUM_PADS); p++) begin
      shift_next_s[p][idx_r] = ~sync_s[p];
    end
  end

  // Frame sequencer: shared timer, bit index, sampling and registered pad/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      timer_r       <= '0;
      idx_r         <= '0;
      shift_r       <= '0;
      buttons_r     <= '0;
      pad_latch_r   <= 1'b0;
      pad_pulse_r   <= 1'b0;
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start || (timer_r == POLL_LAST)) begin
            state_r     <= LATCH;
            timer_r     <= '0;
            pad_latch_r <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        LATCH: begin
          if (timer_r == LATCH_LAST) begin
            state_r     <= SAMPLE;
            timer_r     <= '0;
            idx_r       <= '0;
            pad_latch_r <= 1'b0;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        SAMPLE: begin
          if (sample_end_s) begin
            timer_r <= '0;
            shift_r <= shift_next_s;
            if (frame_end_s) begin
              // Publish the whole word together with the strobe seen in DONE.
              state_r       <= DONE;
              buttons_r     <= shift_next_s;
              frame_valid_r <= 1'b1;
            end else begin
              state_r     <= PULSE_HI;
              pad_pulse_r <= 1'b1;
            end
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        PULSE_HI: begin
          if (timer_r == PULSE_LAST) begin
            state_r     <= SAMPLE;
            timer_r     <= '0;
            idx_r       <= idx_r + IDX_ONE;
            pad_pulse_r <= 1'b0;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        DONE: begin
          state_r       <= IDLE;
          timer_r       <= '0;
          frame_valid_r <= 1'b0;
          busy_r        <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          timer_r       <= '0;
          idx_r         <= '0;
          pad_latch_r   <= 1'b0;
          pad_pulse_r   <= 1'b0;
          frame_valid_r <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign pad_latch   = pad_latch_r;
  assign pad_pulse   = pad_pulse_r;
  assign buttons     = buttons_r;
  assign frame_valid = frame_valid_r;
  assign busy        = busy_r;

`ifdef PAD_EDGE_DET_EN
  logic [NUM_PADS-1:0][NUM_BUTTONS-1:0] pressed_r;

  // Newly pressed buttons, presented only alongside the frame_valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_r <= '0;
    end else if (frame_end_s) begin
      pressed_r <= shift_next_s & ~buttons_r;
    end else begin
      pressed_r <= '0;
    end
  end

  assign pressed = pressed_r;
`endif

endmodule

// File: tb/tb_multi_pad_reader.sv
// Directed self-checking bench for multi_pad_reader with a behavioural 4021 pad model.
// Build with PAD_EDGE_DET_EN defined to also check the `pressed` output.
module tb_multi_pad_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  pad_data;
  logic        pad_latch;
  logic        pad_pulse;
  logic [15:0] buttons;
  logic        frame_valid;
  logic        busy;
`ifdef PAD_EDGE_DET_EN
  logic [15:0] pressed;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Pad model state: pressed buttons (active-high), connection, 4021 shift register.
  logic [7:0] btn  [2];
  logic       conn [2];
  logic [7:0] sr   [2] = '{8'hFF, 8'hFF};
  logic       pulse_q = 1'b0;

  always #5 clk = ~clk;

  multi_pad_reader #(
    .NUM_PADS     (2),
    .NUM_BUTTONS  (8),
    .LATCH_CYCLES (4),
    .PULSE_CYCLES (3),
    .POLL_CYCLES  (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_pulse   (pad_pulse),
    .buttons     (buttons),
    .frame_valid (frame_valid),
    .busy        (busy)
`ifdef PAD_EDGE_DET_EN
    ,
    .pressed     (pressed)
`endif
  );

  // 4021 behaviour: parallel load while latch high, shift toward bit 0 on pulse rise.
  always @(posedge clk) begin
    pulse_q <= pad_pulse;
    for (int p = 0; p < 2; p++) begin
      if (pad_latch) sr[p] <= ~btn[p];
      else if (pad_pulse && !pulse_q) sr[p] <= {1'b1, sr[p][7:1]};
    end
  end

  assign pad_data[0] = conn[0] ? sr[0][0] : 1'b1;
  assign pad_data[1] = conn[1] ? sr[1][0] : 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle start, wait (bounded) for frame_valid and check the result.
  task automatic do_frame(input string tag, input logic [15:0] exp_b, input logic [15:0] exp_pr);
    logic        found;
    logic [15:0] b;
    logic [15:0] pr;
    found = 1'b0;
    b     = 16'h0000;
    pr    = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        found = 1'b1;
        b     = buttons;
`ifdef PAD_EDGE_DET_EN
        pr    = pressed;
`endif
      end
    end
    check({tag, "_found"}, 32'(found), 32'd1);
    check({tag, "_buttons"}, 32'(b), 32'(exp_b));
`ifdef PAD_EDGE_DET_EN
    check({tag, "_pressed"}, 32'(pr), 32'(exp_pr));
`else
    pr = exp_pr;
`endif
    @(negedge clk);
    check({tag, "_fv_low"}, 32'(frame_valid), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
`ifdef PAD_EDGE_DET_EN
    check({tag, "_pressed_low"}, 32'(pressed), 32'd0);
`endif
  endtask

  initial begin
    int   latch_cycles, pulse_rises, pulse_hi_cycles, bad_runs, hi_run;
    int   busy_cycles, low_cycles, overlap, n_latch_rise, latch_rise1, latch_rise2;
    int   n_fv, fv1, fv2, rises;
    logic [15:0] b1, b2;
    logic latch_prev, pulse_prev, hit, found;

    latch_cycles = 0; pulse_rises = 0; pulse_hi_cycles = 0; bad_runs = 0; hi_run = 0;
    busy_cycles = 0; low_cycles = 0; overlap = 0; n_latch_rise = 0;
    latch_rise1 = 0; latch_rise2 = 0; n_fv = 0; fv1 = 0; fv2 = 0;
    b1 = 16'h0000; b2 = 16'h0000; latch_prev = 1'b0; pulse_prev = 1'b0;

    rst = 1'b1; start = 1'b0;
    btn[0] = 8'h00; btn[1] = 8'h00; conn[0] = 1'b1; conn[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_pulse", 32'(pad_pulse), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Frame 1 (A+Start on pad0), timing, then an auto-poll frame with a mid-frame start.
    btn[0] = 8'h09;
    repeat (4) @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 340; k++) begin
      @(negedge clk);
      if (k == 1)   start = 1'b0;
      if (k == 100) begin btn[0] = 8'h81; btn[1] = 8'h3C; end
      if (k == 270) start = 1'b1;
      if (k == 272) start = 1'b0;
      if (pad_latch && !latch_prev) begin
        n_latch_rise++;
        if (n_latch_rise == 1) latch_rise1 = k;
        else if (n_latch_rise == 2) latch_rise2 = k;
      end
      if (k <= 60) begin
        if (pad_latch) latch_cycles++;
        if (pad_pulse && !pulse_prev) pulse_rises++;
        if (pad_pulse) begin
          hi_run++;
          pulse_hi_cycles++;
        end else begin
          if (pulse_prev && hi_run != 3) bad_runs++;
          hi_run = 0;
        end
        if (busy) busy_cycles++;
        if (busy && !pad_latch && !pad_pulse && !frame_valid) low_cycles++;
      end
      if (pad_latch && pad_pulse) overlap++;
      if (frame_valid) begin
        n_fv++;
        if (n_fv == 1) begin fv1 = k; b1 = buttons; end
        else if (n_fv == 2) begin fv2 = k; b2 = buttons; end
      end
      latch_prev = pad_latch;
      pulse_prev = pad_pulse;
    end
    check("t1_buttons", 32'(b1), 32'h0009);
    check("t2_latch_rise_cycle", 32'(latch_rise1), 32'd1);
    check("t2_latch_cycles", 32'(latch_cycles), 32'd4);
    check("t2_pulse_rises", 32'(pulse_rises), 32'd7);
    check("t2_pulse_hi_cycles", 32'(pulse_hi_cycles), 32'd21);
    check("t2_bad_hi_runs", 32'(bad_runs), 32'd0);
    check("t2_sample_low_cycles", 32'(low_cycles), 32'd24);
    check("t2_busy_cycles", 32'(busy_cycles), 32'd50);
    check("t2_done_cycle", 32'(fv1), 32'd50);
    check("t2_overlap", 32'(overlap), 32'd0);
    check("t3_auto_latch_cycle", 32'(latch_rise2), 32'd251);
    check("t3_auto_fv_cycle", 32'(fv2), 32'd300);
    check("t3_auto_buttons", 32'(b2), 32'h3C81);
    check("t3_frame_count", 32'(n_fv), 32'd2);
    check("t3_latch_count", 32'(n_latch_rise), 32'd2);

    // Reset during PULSE_HI of bit 4 aborts the frame.
    btn[0] = 8'h55; btn[1] = 8'hAA;
    hit = 1'b0; rises = 0; pulse_prev = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (pad_pulse && !pulse_prev) begin
        rises++;
        if (rises == 5) hit = 1'b1;
      end
      pulse_prev = pad_pulse;
    end
    check("t4_reached_bit4", 32'(hit), 32'd1);
    check("t4_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_latch", 32'(pad_latch), 32'd0);
    check("t4_pulse", 32'(pad_pulse), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_fv", 32'(frame_valid), 32'd0);
    check("t4_buttons", 32'(buttons), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_valid) found = 1'b1;
    end
    check("t4_no_frame_after_abort", 32'(found), 32'd0);
    do_frame("t4_post_rst", 16'hAA55, 16'hAA55);

    // Pad0 disconnected, pad1 all pressed.
    conn[0] = 1'b0; btn[1] = 8'hFF;
    do_frame("t5_disc", 16'hFF00, 16'h5500);

    // Edge-detect sequence on pad0.
    conn[0] = 1'b1; btn[1] = 8'h00;
    btn[0] = 8'h01;
    do_frame("t6_f1", 16'h0001, 16'h0001);
    btn[0] = 8'h03;
    do_frame("t6_f2", 16'h0003, 16'h0002);
    btn[0] = 8'h02;
    do_frame("t6_f3", 16'h0002, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
